// File: rtl/uart_rcv_cfg_if.sv
// Byte-side interface of the configurable UART receiver: baud setup,
// ready/clear handshake, received word and status flags.
interface uart_rcv_cfg_if #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
);
  logic [DIV_W-1:0]     baud_div;
  logic                 rx_rdy_clr;
  logic                 rx_rdy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output baud_div, rx_rdy_clr,
    input  rx_rdy, rx_data, parity_err, frame_err, overrun
  );

  modport slave (
    input  baud_div, rx_rdy_clr,
    output rx_rdy, rx_data, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/uart_rcv_cfg.sv
// Configurable asynchronous serial receiver: elaboration-time frame format,
// run-time baud divisor, 3-sample majority voting, false-start rejection,
// parity/framing/overrun status.
module uart_rcv_cfg #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int DIV_W     = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           RX,
  uart_rcv_cfg_if.slave  bus
);

  localparam int   P   = (PARITY != 0) ? 1 : 0;
  localparam int   S   = 1 + DATA_BITS + P;
  localparam int   BW  = $clog2(S + 1);
  localparam logic ODD = (PARITY == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic                 sync1, sync2, sync_prev;
  logic                 edge_det;
  logic [DIV_W-1:0]     div_q, cnt, half, div_eff;
  logic [BW-1:0]        bit_idx;
  logic                 v0, v1, vote, decide;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;

  assign edge_det = sync_prev & ~sync2;
  assign half     = div_q >> 1;
  assign decide   = (cnt == half + DIV_W'(1));
  assign vote     = (v0 & v1) | (v0 & sync2) | (v1 & sync2);
  assign div_eff  = (bus.baud_div < DIV_W'(8)) ? DIV_W'(8) : bus.baud_div;

  // Two-flop synchroniser plus one history flop for fall detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= RX;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  // Frame FSM with baud/bit counters, vote capture and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      div_q          <= '0;
      cnt            <= '0;
      bit_idx        <= '0;
      v0             <= 1'b1;
      v1             <= 1'b1;
      shreg          <= '0;
      perr           <= 1'b0;
      bus.rx_rdy     <= 1'b0;
      bus.rx_data    <= '0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      if (bus.rx_rdy_clr) begin
        bus.rx_rdy  <= 1'b0;
        bus.overrun <= 1'b0;
      end

      if (state != IDLE) begin
        if (cnt == div_q - DIV_W'(1)) begin
          cnt     <= '0;
          bit_idx <= bit_idx + BW'(1);
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
        if (cnt == half - DIV_W'(1)) v0 <= sync2;
        if (cnt == half)             v1 <= sync2;
      end

      case (state)
        IDLE: begin
          if (edge_det) begin
            div_q   <= div_eff;
            cnt     <= '0;
            bit_idx <= '0;
            perr    <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (decide) state <= vote ? IDLE : DATA;
        end
        DATA: begin
          if (decide) begin
            shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (bit_idx == BW'(DATA_BITS)) state <= (P != 0) ? PAR : STOP;
          end
        end
        PAR: begin
          if (decide) begin
            perr  <= (^shreg) ^ vote ^ ODD;
            state <= STOP;
          end
        end
        STOP: begin
          if (decide) begin
            bus.rx_data    <= shreg;
            bus.parity_err <= perr;
            bus.frame_err  <= ~vote;
            bus.rx_rdy     <= 1'b1;
            // completion overrides a coincident clear; that clear still
            // drops any earlier overrun and this frame does not raise one
            bus.overrun    <= bus.rx_rdy_clr ? 1'b0 : (bus.overrun | bus.rx_rdy);
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rcv_cfg.sv
// Bench for uart_rcv_cfg: an 8N1 instance and a 7E1 instance driven with
// directed frames; a frame-level model predicts completion cycle and contents.
module tb_uart_rcv_cfg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   tot_cnt = 0;

  uart_rcv_cfg_if #(.DATA_BITS(8), .DIV_W(16)) b0 ();
  uart_rcv_cfg_if #(.DATA_BITS(7), .DIV_W(16)) b1 ();

  uart_rcv_cfg #(.DATA_BITS(8), .PARITY(0), .DIV_W(16)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .RX(rx0), .bus(b0));
  uart_rcv_cfg #(.DATA_BITS(7), .PARITY(1), .DIV_W(16)) u_7e1 (
    .clk(clk), .rst_n(rst_n), .RX(rx1), .bus(b1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    int         cyc;
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } ev_t;

  ev_t        evq[$];
  logic       m_rdy[2], m_ovr[2], m_pe[2], m_fe[2];
  logic [8:0] m_data[2];
  logic       clr_last[2], prev_rdy[2];
  int         last_rise[2], rise_cnt[2];
  logic       hit;
  ev_t        e;
  logic       a_rdy, a_pe, a_fe, a_ovr;
  logic [8:0] a_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Model update and per-cycle output comparison, away from the active edge
  always @(negedge clk) begin
    for (int id = 0; id < 2; id++) begin
      if (!rst_n) begin
        m_rdy[id] = 0; m_ovr[id] = 0; m_pe[id] = 0; m_fe[id] = 0; m_data[id] = '0;
        clr_last[id] = 0;
      end else begin
        hit = 0;
        for (int k = 0; k < evq.size(); k++) begin
          if (evq[k].id == id && evq[k].cyc == cyc) begin
            e = evq[k];
            hit = 1;
            evq.delete(k);
            break;
          end
        end
        if (hit) begin
          m_ovr[id]  = clr_last[id] ? 1'b0 : (m_ovr[id] | m_rdy[id]);
          m_rdy[id]  = 1;
          m_data[id] = e.d;
          m_pe[id]   = e.pe;
          m_fe[id]   = e.fe;
        end else if (clr_last[id]) begin
          m_rdy[id] = 0;
          m_ovr[id] = 0;
        end
      end
      if (id == 0) begin
        a_rdy = b0.rx_rdy; a_data = 9'(b0.rx_data); a_pe = b0.parity_err;
        a_fe = b0.frame_err; a_ovr = b0.overrun; clr_last[0] = b0.rx_rdy_clr;
      end else begin
        a_rdy = b1.rx_rdy; a_data = 9'(b1.rx_data); a_pe = b1.parity_err;
        a_fe = b1.frame_err; a_ovr = b1.overrun; clr_last[1] = b1.rx_rdy_clr;
      end
      if (!rst_n) clr_last[id] = 0;
      chk($sformatf("rx_rdy[%0d]", id), 32'(a_rdy), 32'(m_rdy[id]));
      chk($sformatf("rx_data[%0d]", id), 32'(a_data), 32'(m_data[id]));
      chk($sformatf("parity_err[%0d]", id), 32'(a_pe), 32'(m_pe[id]));
      chk($sformatf("frame_err[%0d]", id), 32'(a_fe), 32'(m_fe[id]));
      chk($sformatf("overrun[%0d]", id), 32'(a_ovr), 32'(m_ovr[id]));
      if (a_rdy && !prev_rdy[id]) begin
        last_rise[id] = cyc;
        rise_cnt[id]++;
      end
      prev_rdy[id] = a_rdy;
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int id, input logic v);
    if (id == 0) rx0 = v; else rx1 = v;
  endtask

  // Drives one frame starting now and queues its expected completion.
  task automatic send_frame(input int id, input logic [8:0] d, input int nb,
                            input int pmode, input logic flip_par,
                            input logic stopv, input int div,
                            input int stop_hold, input logic [15:0] junk_div);
    int eff, s, n;
    logic [8:0] dm;
    logic pbit;
    ev_t ev;
    eff = (div < 8) ? 8 : div;
    s   = 1 + nb + ((pmode != 0) ? 1 : 0);
    dm  = d & 9'((1 << nb) - 1);
    pbit = (pmode == 2) ? ~(^dm) : (^dm);
    if (flip_par) pbit = ~pbit;
    n = cyc;
    ev.id  = id;
    ev.cyc = n + 5 + s * eff + eff / 2;
    ev.d   = dm;
    ev.pe  = (pmode == 1) ? ((^dm) ^ pbit) : (pmode == 2) ? ~((^dm) ^ pbit) : 1'b0;
    ev.fe  = ~stopv;
    evq.push_back(ev);
    set_rx(id, 1'b0);
    tick(eff);
    if (id == 0) b0.baud_div = junk_div; else b1.baud_div = junk_div;
    for (int i = 0; i < nb; i++) begin
      set_rx(id, dm[i]);
      tick(eff);
    end
    if (pmode != 0) begin
      set_rx(id, pbit);
      tick(eff);
    end
    set_rx(id, stopv);
    tick(stop_hold);
  endtask

  task automatic clr_pulse(input int id);
    if (id == 0) b0.rx_rdy_clr = 1; else b1.rx_rdy_clr = 1;
    tick(1);
    if (id == 0) b0.rx_rdy_clr = 0; else b1.rx_rdy_clr = 0;
    tick(2);
  endtask

  initial begin
    int n, comp;
    logic [7:0] d99;
    b0.baud_div = 16; b0.rx_rdy_clr = 0;
    b1.baud_div = 16; b1.rx_rdy_clr = 0;
    for (int i = 0; i < 2; i++) begin
      last_rise[i] = -1; rise_cnt[i] = 0; prev_rdy[i] = 0;
    end
    tick(4);
    chk("reset rx_rdy", 32'(b0.rx_rdy), 32'd0);
    chk("reset rx_data", 32'(b0.rx_data), 32'd0);
    rst_n = 1;
    tick(5);

    // 8N1 0xA5 at div 16: rx_rdy rises t0+155, t0 = drive cycle + 2
    n = cyc;
    send_frame(0, 9'hA5, 8, 0, 0, 1, 16, 16, 16'd16);
    tick(10);
    chk("A5 rise cycle", 32'(last_rise[0] - n), 32'd157);
    chk("A5 data", 32'(b0.rx_data), 32'hA5);
    clr_pulse(0);
    chk("A5 clr rdy", 32'(b0.rx_rdy), 32'd0);
    chk("A5 clr keeps data", 32'(b0.rx_data), 32'hA5);

    // 3-clock glitch: false start, nothing changes
    rx0 = 0; tick(3); rx0 = 1; tick(40);
    chk("glitch rise count", 32'(rise_cnt[0]), 32'd1);

    // 0x3C with stop bit 0 and line held low 40 bits
    send_frame(0, 9'h3C, 8, 0, 0, 0, 16, 40 * 16, 16'd16);
    rx0 = 1; tick(40);
    chk("break frame_err", 32'(b0.frame_err), 32'd1);
    chk("break one frame", 32'(rise_cnt[0]), 32'd2);
    clr_pulse(0);

    // back-to-back 0x11, 0x22 without clear
    send_frame(0, 9'h11, 8, 0, 0, 1, 16, 16, 16'd16);
    send_frame(0, 9'h22, 8, 0, 0, 1, 16, 16, 16'd16);
    tick(5);
    chk("b2b data", 32'(b0.rx_data), 32'h22);
    chk("b2b overrun", 32'(b0.overrun), 32'd1);
    clr_pulse(0);
    chk("b2b clr overrun", 32'(b0.overrun), 32'd0);
    chk("b2b clr data", 32'(b0.rx_data), 32'h22);

    // divisor below 8 clamps to 8; mid-frame divisor change ignored
    b0.baud_div = 5;
    n = cyc;
    send_frame(0, 9'hC3, 8, 0, 0, 1, 5, 8, 16'd40);
    tick(5);
    chk("clamp rise cycle", 32'(last_rise[0] - n), 32'd81);
    chk("clamp data", 32'(b0.rx_data), 32'hC3);
    b0.baud_div = 16;
    clr_pulse(0);

    // clear coincident with completion: completion wins
    send_frame(0, 9'h66, 8, 0, 0, 1, 16, 24, 16'd16);
    comp = cyc + 5 + 9 * 16 + 8;
    fork
      send_frame(0, 9'h77, 8, 0, 0, 1, 16, 24, 16'd16);
      begin
        tick(comp - 1 - cyc);
        b0.rx_rdy_clr = 1;
        tick(1);
        b0.rx_rdy_clr = 0;
      end
    join
    chk("coincident rdy", 32'(b0.rx_rdy), 32'd1);
    chk("coincident overrun", 32'(b0.overrun), 32'd0);
    chk("coincident data", 32'(b0.rx_data), 32'h77);

    // 7E1: 0x35 has four ones, even parity bit is 0
    send_frame(1, 9'h35, 7, 1, 1, 1, 16, 24, 16'd16);
    chk("7E1 bad parity", 32'(b1.parity_err), 32'd1);
    chk("7E1 data", 32'(b1.rx_data), 32'h35);
    send_frame(1, 9'h35, 7, 1, 0, 1, 16, 24, 16'd16);
    chk("7E1 good parity", 32'(b1.parity_err), 32'd0);

    // reset during data bit 4 of a frame
    d99 = 8'h99;
    rx0 = 0; tick(16);
    for (int i = 0; i < 4; i++) begin
      rx0 = d99[i]; tick(16);
    end
    rx0 = d99[4]; tick(8);
    rst_n = 0;
    #1;
    chk("midreset rdy", 32'(b0.rx_rdy), 32'd0);
    chk("midreset data", 32'(b0.rx_data), 32'd0);
    chk("midreset overrun", 32'(b0.overrun), 32'd0);
    chk("midreset rdy 7E1", 32'(b1.rx_rdy), 32'd0);
    rx0 = 1;
    tick(3);
    rst_n = 1;
    tick(5);
    b0.baud_div = 20;
    n = cyc;
    send_frame(0, 9'h5A, 8, 0, 0, 1, 20, 20, 16'd20);
    tick(10);
    chk("5A rise cycle", 32'(last_rise[0] - n), 32'd195);
    chk("5A data", 32'(b0.rx_data), 32'h5A);
    chk("no stray events", 32'(evq.size()), 32'd0);

    tick(10);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rcv_cfg.md
# uart_rcv_cfg

Parametrised asynchronous serial receiver. It supersedes the fixed 8N1 receiver: frame format is set at elaboration, and baud divisor is set at run time. It adds 3-sample majority voting, false-start rejection, and parity/framing/overrun status. It sits between the external RX pin and the command/byte-handling logic, which consumes bytes via the rx_rdy / rx_rdy_clr handshake.

## Interface
- DATA_BITS, 8, data bits per frame; legal 5..9; LSB received first.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- DIV_W, 16, width of baud_div and the internal baud counter.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- RX  in  1  serial line, idle high; asynchronous to clk.
- baud_div  in  DIV_W  clocks per bit; sampled only at start detection; values < 8 treated as 8.
- rx_rdy_clr  in  1  pulse to clear rx_rdy and overrun.
- rx_rdy  out  1  a completed frame is held in rx_data.
- rx_data  out  DATA_BITS  last received data word.
- parity_err  out  1  parity mismatch in the frame held in rx_data; always 0 when PARITY=0.
- frame_err  out  1  stop bit voted 0 in the frame held in rx_data.
- overrun  out  1  a frame completed while rx_rdy was already 1; sticky.

## Operation
- RX passes through a 2-flop synchroniser. Both flops reset to 1. Fall detection uses the synchroniser output and its previous value (edge_det).
- Let P = (PARITY != 0), S = 1 + DATA_BITS + P (index of the stop bit), and h = div/2 (floor). div is the latched baud_div.
- States: IDLE, START, DATA, PAR, STOP.
  - IDLE: on edge_det, latch div, clear the baud counter and bit counter, then go to START.
- Baud counter: runs 0..div-1 and wraps; bit k spans counter laps k = 0..S.
- Per bit, votes are sampled at counter values h-1, h and h+1. The bit value is the majority of the three, decided at counter = h+1.
- START: voted 1 → false start. Return to IDLE; no outputs change. Voted 0 → DATA.
- DATA: DATA_BITS decisions, shifted right into the data register (LSB first). Then go to PAR if P, else STOP.
- PAR: compute the parity error. Even mode: XOR of data and parity bit must be 0. Odd mode: it must be 1.
- STOP: at the stop-bit decision, do all of the following in the same edge, then go to IDLE:
  - load rx_data;
  - set parity_err;
  - set frame_err = ~vote;
  - set rx_rdy = 1;
  - if rx_rdy was already 1, set overrun = 1.
- Returning to IDLE at mid-stop-bit permits back-to-back frames.
- Only the first stop bit is checked. The line may idle any length afterwards.
- After a frame_err (line held low, e.g. a break), no new start is detected until the line returns high and falls again.
- rx_rdy_clr clears rx_rdy and overrun. It does not clear rx_data or the error flags.
- Frame completion and rx_rdy_clr in the same cycle: completion wins. rx_rdy stays 1 and overrun is not set by that frame.
- A new start does not clear rx_rdy.
- Changes on baud_div mid-frame are ignored until the next IDLE → START.
- Reset state: state IDLE, counters 0, synchroniser 1, and all outputs 0 (rx_rdy, rx_data, parity_err, frame_err, overrun).
- Reset asserted mid-frame aborts the frame with no partial outputs. The next valid frame after release is received normally.

## Timing
- RX pin fall to edge_det: 2 to 3 clk, depending on synchroniser phase.
- With t0 = the cycle edge_det is 1: the counter is 0 in cycle t0+1, and rx_rdy is first 1 in cycle t0 + S·div + h + 3.
  - Example: 8N1, div=16 → t0+155.
- rx_data and the flags change only in that same cycle, and are stable until the next frame completes.
- rx_rdy_clr asserted in cycle t → rx_rdy = 0 in cycle t+1 (unless a frame completes in cycle t).
- Minimum glitch rejected: any low pulse that does not cover at least 2 of the 3 start-bit votes.

## Test plan
- 8N1, baud_div=16, send 0xA5 then stop → rx_data=0xA5, rx_rdy rises exactly t0+155, parity_err=frame_err=overrun=0.
- baud_div=16, RX low for 3 clk only → edge_det fires, START votes all 1, back to IDLE. rx_rdy stays 0 and no flags change.
- PARITY=1, DATA_BITS=7, send 0x35 with parity bit 1 (wrong; even requires 0) → rx_data=0x35, parity_err=1; repeat with correct bit → parity_err=0.
- 8N1, send 0x3C with stop bit 0 and hold the line low for 40 bits → frame_err=1, exactly one rx_rdy. No second frame until RX returns high then falls.
- Two back-to-back frames, 0x11 then 0x22, without rx_rdy_clr → rx_data=0x22, overrun=1. Pulse rx_rdy_clr → rx_rdy=0 and overrun=0, rx_data still 0x22. Also a clr coincident with completion → rx_rdy stays 1.
- Assert rst_n low during data bit 4 of a frame → all outputs 0 immediately; release, send 0x5A at baud_div=20 → rx_data=0x5A, rx_rdy at t0+9·20+10+3.
